// File: rtl/blit_addr_seq_pkg.sv
// Shared blitter definitions: adder B-select codes, sequencer states and control decode.
package blit_addr_seq_pkg;

  localparam int unsigned CNT_W_DEF = 16;

  localparam logic [1:0] ADDB_A1     = 2'b00;
  localparam logic [1:0] ADDB_A2     = 2'b01;
  localparam logic [1:0] ADDB_A1FRAC = 2'b10;
  localparam logic [1:0] ADDB_A1STEP = 2'b11;

  typedef enum logic [2:0] {
    IDLE, PIX, A1_INC, A2_INC, A1F_STEP, A1_STEP, A2_STEP, DONE
  } state_t;

  typedef struct packed {
    logic [1:0] addbsel;
    logic       adda_step;
    logic       a1_ld;
    logic       a1f_ld;
    logic       a2_ld;
    logic       busy;
    logic       done;
  } addr_ctl_t;

  // Address-datapath controls for a given sequencer state.
  function automatic addr_ctl_t decode_ctl(state_t st);
    addr_ctl_t c;
    c      = '0;
    c.busy = (st != IDLE);
    case (st)
      A1_INC:   begin c.addbsel = ADDB_A1;     c.a1_ld  = 1'b1; end
      A2_INC:   begin c.addbsel = ADDB_A2;     c.a2_ld  = 1'b1; end
      A1F_STEP: begin c.addbsel = ADDB_A1FRAC; c.a1f_ld = 1'b1; c.adda_step = 1'b1; end
      A1_STEP:  begin c.addbsel = ADDB_A1STEP; c.a1_ld  = 1'b1; c.adda_step = 1'b1; end
      A2_STEP:  begin c.addbsel = ADDB_A2;     c.a2_ld  = 1'b1; c.adda_step = 1'b1; end
      DONE:     c.done = 1'b1;
      default:  ;
    endcase
    return c;
  endfunction

  // Next enabled end-of-line step after `cur`; IDLE means no further step (line end).
  function automatic state_t next_step(state_t cur, logic upda1f, logic upda1, logic upda2);
    state_t ns;
    ns = IDLE;
    if ((cur == A1_INC || cur == A2_INC) && upda1f)
      ns = A1F_STEP;
    else if (cur != A1_STEP && cur != A2_STEP && upda1)
      ns = A1_STEP;
    else if (cur != A2_STEP && upda2)
      ns = A2_STEP;
    return ns;
  endfunction

endpackage

// File: rtl/blit_addr_seq_loop_counter.sv
// Loadable down-counter with a look-ahead flag for "next decrement reaches zero".
module loop_counter
  import blit_addr_seq_pkg::*;
#(
  parameter int unsigned W = CNT_W_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         dec_zero_c
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (dec)
      count <= count - W'(1);
  end

  assign dec_zero_c = (count == W'(1));

endmodule

// File: rtl/blit_addr_seq.sv
// Blitter address-update sequencer: walks pixel/line loops and time-shares the address adder.
module blit_addr_seq
  import blit_addr_seq_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] inner_cnt,
  input  logic [CNT_W-1:0] outer_cnt,
  input  logic             upda1f,
  input  logic             upda1,
  input  logic             upda2,
  input  logic             a2_en,
  input  logic             pix_ack,
  output logic [1:0]       addbsel,
  output logic             adda_step,
  output logic             a1_ld,
  output logic             a1f_ld,
  output logic             a2_ld,
  output logic             busy,
  output logic             done
);

  state_t    state_q, state_d;
  addr_ctl_t ctl_q;
  logic      upda1f_q, upda1_q, upda2_q, a2_en_q;
  logic      in_load, in_dec, out_load, out_dec, flags_load;
  logic      in_last_c, out_last_c;

  loop_counter #(.W(CNT_W)) u_inner (
    .clk(sys_clk), .reset(reset), .load(in_load), .dec(in_dec),
    .load_val(inner_cnt), .dec_zero_c(in_last_c)
  );

  loop_counter #(.W(CNT_W)) u_outer (
    .clk(sys_clk), .reset(reset), .load(out_load), .dec(out_dec),
    .load_val(outer_cnt), .dec_zero_c(out_last_c)
  );

  // Outputs are registered from the next-state decode so they track the state register.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q  <= IDLE;
      ctl_q    <= '0;
      upda1f_q <= 1'b0;
      upda1_q  <= 1'b0;
      upda2_q  <= 1'b0;
      a2_en_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ctl_q   <= decode_ctl(state_d);
      if (flags_load) begin
        upda1f_q <= upda1f;
        upda1_q  <= upda1;
        upda2_q  <= upda2;
        a2_en_q  <= a2_en;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    in_load    = 1'b0;
    in_dec     = 1'b0;
    out_load   = 1'b0;
    out_dec    = 1'b0;
    flags_load = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (inner_cnt == '0 || outer_cnt == '0) begin
            state_d = DONE;
          end else begin
            state_d    = PIX;
            in_load    = 1'b1;
            out_load   = 1'b1;
            flags_load = 1'b1;
          end
        end
      end
      PIX:    if (pix_ack) state_d = A1_INC;
      A1_INC: begin
        if (a2_en_q) begin
          state_d = A2_INC;
        end else begin
          in_dec  = 1'b1;
          state_d = in_last_c ? next_step(A1_INC, upda1f_q, upda1_q, upda2_q) : PIX;
        end
      end
      A2_INC: begin
        in_dec  = 1'b1;
        state_d = in_last_c ? next_step(A2_INC, upda1f_q, upda1_q, upda2_q) : PIX;
      end
      A1F_STEP, A1_STEP, A2_STEP:
        state_d = next_step(state_q, upda1f_q, upda1_q, upda2_q);
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A busy loop state resolving to IDLE marks line end: advance the outer loop instead.
    if (state_q != IDLE && state_q != DONE && state_d == IDLE) begin
      out_dec = 1'b1;
      if (out_last_c) begin
        state_d = DONE;
      end else begin
        state_d = PIX;
        in_load = 1'b1;
      end
    end
  end

  assign addbsel   = ctl_q.addbsel;
  assign adda_step = ctl_q.adda_step;
  assign a1_ld     = ctl_q.a1_ld;
  assign a1f_ld    = ctl_q.a1f_ld;
  assign a2_ld     = ctl_q.a2_ld;
  assign busy      = ctl_q.busy;
  assign done      = ctl_q.done;

endmodule

// File: tb/tb_blit_addr_seq.sv
// Scoreboard bench for blit_addr_seq: expected load/done events are queued, a monitor checks them.
module tb_blit_addr_seq;

  logic        sys_clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] inner_cnt = '0;
  logic [15:0] outer_cnt = '0;
  logic        upda1f = 1'b0, upda1 = 1'b0, upda2 = 1'b0, a2_en = 1'b0;
  logic        pix_ack = 1'b1;
  logic [1:0]  addbsel;
  logic        adda_step, a1_ld, a1f_ld, a2_ld, busy, done;

  // {done, addbsel, adda_step, a1_ld, a1f_ld, a2_ld}
  localparam logic [6:0] E_A1I = 7'b0_00_0_1_0_0;
  localparam logic [6:0] E_A2I = 7'b0_01_0_0_0_1;
  localparam logic [6:0] E_A1F = 7'b0_10_1_0_1_0;
  localparam logic [6:0] E_A1S = 7'b0_11_1_1_0_0;
  localparam logic [6:0] E_A2S = 7'b0_01_1_0_0_1;
  localparam logic [6:0] E_DON = 7'b1_00_0_0_0_0;

  logic [6:0] sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  blit_addr_seq #(.CNT_W(16)) dut (
    .sys_clk(sys_clk), .reset(reset), .start(start),
    .inner_cnt(inner_cnt), .outer_cnt(outer_cnt),
    .upda1f(upda1f), .upda1(upda1), .upda2(upda2), .a2_en(a2_en),
    .pix_ack(pix_ack), .addbsel(addbsel), .adda_step(adda_step),
    .a1_ld(a1_ld), .a1f_ld(a1f_ld), .a2_ld(a2_ld), .busy(busy), .done(done)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every cycle with a load or done must match the head of the scoreboard.
  always @(negedge sys_clk) begin : monitor
    logic [6:0] got;
    logic [6:0] exp;
    got = {done, addbsel, adda_step, a1_ld, a1f_ld, a2_ld};
    if ({done, a1_ld, a1f_ld, a2_ld} != 4'b0000) begin
      chk("one_load", 32'($countones({a1_ld, a1f_ld, a2_ld}) <= 1), 32'd1);
      if (sb.size() == 0) begin
        chk("unexpected_out", 32'(got), 32'd0);
      end else begin
        exp = sb.pop_front();
        chk("out_seq", 32'(got), 32'(exp));
      end
    end
  end

  task automatic launch(input logic [15:0] ic, input logic [15:0] oc,
                        input logic a2, input logic f, input logic s1, input logic s2);
    @(posedge sys_clk); #1;
    inner_cnt = ic; outer_cnt = oc;
    a2_en = a2; upda1f = f; upda1 = s1; upda2 = s2;
    start = 1'b1;
    @(posedge sys_clk); #1;
    start = 1'b0;
  endtask

  // Counts busy cycles until idle; optionally pulses start at busy cycle `poke`.
  task automatic wait_idle(input string nm, input int exp_busy, input int poke);
    int  cnt = 0;
    bit  fin = 1'b0;
    for (int i = 0; i < 300 && !fin; i++) begin
      @(negedge sys_clk);
      if (busy) begin
        cnt++;
        start = (cnt == poke);
      end else begin
        start = 1'b0;
        fin   = 1'b1;
      end
    end
    if (!fin) chk({nm, "_timeout"}, 32'd0, 32'd1);
    chk({nm, "_busy_cycles"}, 32'(cnt), 32'(exp_busy));
    chk({nm, "_drained"}, 32'(sb.size()), 32'd0);
  endtask

  task automatic push_t1();
    sb.push_back(E_A1I); sb.push_back(E_A1I); sb.push_back(E_A1I); sb.push_back(E_DON);
  endtask

  initial begin
    // Reset, with start held: reset must win.
    start = 1'b1;
    inner_cnt = 16'd3; outer_cnt = 16'd1;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ctl", 32'({addbsel, adda_step, a1_ld, a1f_ld, a2_ld}), 32'd0);
    @(posedge sys_clk); #1;
    reset = 1'b0; start = 1'b0;

    // Three pixels, A1 only.
    push_t1();
    launch(16'd3, 16'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_idle("t1", 7, 0);

    // Two lines of two pixels, A2 active, all steps enabled.
    for (int l = 0; l < 2; l++) begin
      sb.push_back(E_A1I); sb.push_back(E_A2I); sb.push_back(E_A1I); sb.push_back(E_A2I);
      sb.push_back(E_A1F); sb.push_back(E_A1S); sb.push_back(E_A2S);
    end
    sb.push_back(E_DON);
    launch(16'd2, 16'd2, 1'b1, 1'b1, 1'b1, 1'b1);
    wait_idle("t2", 19, 0);

    // Zero counts: straight to done, no loads.
    sb.push_back(E_DON);
    launch(16'd0, 16'd4, 1'b1, 1'b1, 1'b1, 1'b1);
    wait_idle("t3_inner0", 1, 0);
    sb.push_back(E_DON);
    launch(16'd4, 16'd0, 1'b1, 1'b1, 1'b1, 1'b1);
    wait_idle("t3_outer0", 1, 0);

    // pix_ack low for 5 PIX cycles.
    pix_ack = 1'b0;
    sb.push_back(E_A1I); sb.push_back(E_A1I); sb.push_back(E_DON);
    launch(16'd2, 16'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge sys_clk);
      chk("stall_busy", 32'(busy), 32'd1);
      chk("stall_noload", 32'({a1_ld, a1f_ld, a2_ld}), 32'd0);
    end
    pix_ack = 1'b1;
    wait_idle("t4", 4, 0);

    // Reset while in A2_STEP.
    sb.push_back(E_A1I); sb.push_back(E_A2I); sb.push_back(E_A2S);
    launch(16'd1, 16'd1, 1'b1, 1'b0, 1'b0, 1'b1);
    repeat (3) @(posedge sys_clk);
    #1 reset = 1'b1;
    @(posedge sys_clk); #1;
    reset = 1'b0;
    @(negedge sys_clk);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_done", 32'(done), 32'd0);
    chk("t5_ctl", 32'({addbsel, adda_step, a1_ld, a1f_ld, a2_ld}), 32'd0);
    chk("t5_drained", 32'(sb.size()), 32'd0);
    push_t1();
    launch(16'd3, 16'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_idle("t5_clean", 7, 0);

    // inner_cnt re-sampled at line reload; A1 step only.
    sb.push_back(E_A1I); sb.push_back(E_A1S);
    sb.push_back(E_A1I); sb.push_back(E_A1I); sb.push_back(E_A1S); sb.push_back(E_DON);
    launch(16'd1, 16'd2, 1'b0, 1'b0, 1'b1, 1'b0);
    inner_cnt = 16'd2;
    wait_idle("t6", 9, 0);

    // Second start mid-blit with changed inputs is ignored.
    sb.push_back(E_A1I); sb.push_back(E_A1I); sb.push_back(E_DON);
    launch(16'd2, 16'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    inner_cnt = 16'd9; outer_cnt = 16'd9;
    a2_en = 1'b1; upda1f = 1'b1; upda1 = 1'b1; upda2 = 1'b1;
    wait_idle("t7", 5, 2);

    repeat (3) @(negedge sys_clk);
    chk("final_idle", 32'(busy), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
